i2c_bus_arbiter: RTL

//  Shares one I2C byte-write master ({dev,sub,data} 24-bit transfer, go/end/nack handshake) between two

---
 rtl/i2c_arb_pkg.sv | 34 +++
 rtl/i2c_arb_sync.sv | 25 ++
 rtl/i2c_bus_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types for the two-requester I2C byte-write arbiter: FSM states, status codes, word width
// and the round-robin pick helper.
package i2c_arb_pkg;

  localparam int I2C_WORD_W = 24;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GO_WAIT = 3'd1,
    S_RELEASE = 3'd2,
    S_RETRY   = 3'd3,
    S_RESP    = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_NACK    = 2'b01,
    ST_TIMEOUT = 2'b10
  } arb_status_e;

  // On a tie the requester that was not served last wins; 1 selects requester 1.
  function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
    logic g;
    if (v0 && v1) begin
      g = ~last;
    end else if (v1) begin
      g = 1'b1;
    end else begin
      g = 1'b0;
    end
    return g;
  endfunction

endpackage

// File: rtl/i2c_arb_sync.sv
// Two-flop synchronizer bringing the master's end/nack levels into the clk domain.
module i2c_arb_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] d,
  output logic [1:0] q
);

  logic [1:0] meta_r;
  logic [1:0] sync_r;

  // Double-register the asynchronous inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 2'b00;
      sync_r <= 2'b00;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C byte-write master between two requesters, with bus-hang timeout.
// Define I2C_ARB_RETRY_EN to re-attempt NACKed transfers up to MAX_RETRY extra times.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_000_000
`ifdef I2C_ARB_RETRY_EN
  , parameter int MAX_RETRY = 3
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [I2C_WORD_W-1:0] req0_data,
  output logic                  req0_ready,
  output logic                  req0_done,
  input  logic                  req1_valid,
  input  logic [I2C_WORD_W-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  req1_done,
  output logic [1:0]            status,
  output logic                  busy,
  output logic [I2C_WORD_W-1:0] i2c_data,
  output logic                  i2c_go,
  input  logic                  i2c_end,
  input  logic                  i2c_nack
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  arb_state_e            state_r, state_nxt_s;
  logic                  go_r, go_nxt_s;
  logic [I2C_WORD_W-1:0] data_r, data_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  ready0_r, ready0_nxt_s, ready1_r, ready1_nxt_s;
  logic                  done0_r, done0_nxt_s, done1_r, done1_nxt_s;
  logic [1:0]            status_r, status_nxt_s;
  logic [1:0]            res_r, res_nxt_s;
  logic                  grant_r, grant_nxt_s;
  logic                  last_grant_r, last_grant_nxt_s;
  logic [TMR_W-1:0]      timer_r, timer_nxt_s;
  logic                  nack_r, nack_nxt_s;
  logic [1:0]            sync_q_s;
  logic                  end_s, nack_s, pick_s;

`ifdef I2C_ARB_RETRY_EN
  localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_RETRY);
  logic [RC_W-1:0] retry_cnt_r, retry_cnt_nxt_s;

  // Retry counter register, cleared on every new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt_r <= '0;
    end else begin
      retry_cnt_r <= retry_cnt_nxt_s;
    end
  end
`endif

  i2c_arb_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({i2c_nack, i2c_end}),
    .q     (sync_q_s)
  );

  assign end_s  = sync_q_s[0];
  assign nack_s = sync_q_s[1];
  assign pick_s = pick_grant(req0_valid, req1_valid, last_grant_r);

  // State and registered-output flops; last_grant starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      go_r         <= 1'b0;
      data_r       <= '0;
      busy_r       <= 1'b0;
      ready0_r     <= 1'b0;
      ready1_r     <= 1'b0;
      done0_r      <= 1'b0;
      done1_r      <= 1'b0;
      status_r     <= 2'b00;
      res_r        <= 2'b00;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      timer_r      <= '0;
      nack_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      go_r         <= go_nxt_s;
      data_r       <= data_nxt_s;
      busy_r       <= busy_nxt_s;
      ready0_r     <= ready0_nxt_s;
      ready1_r     <= ready1_nxt_s;
      done0_r      <= done0_nxt_s;
      done1_r      <= done1_nxt_s;
      status_r     <= status_nxt_s;
      res_r        <= res_nxt_s;
      grant_r      <= grant_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      timer_r      <= timer_nxt_s;
      nack_r       <= nack_nxt_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s      = state_r;
    go_nxt_s         = go_r;
    data_nxt_s       = data_r;
    busy_nxt_s       = busy_r;
    ready0_nxt_s     = 1'b0;
    ready1_nxt_s     = 1'b0;
    done0_nxt_s      = 1'b0;
    done1_nxt_s      = 1'b0;
    status_nxt_s     = status_r;
    res_nxt_s        = res_r;
    grant_nxt_s      = grant_r;
    last_grant_nxt_s = last_grant_r;
    timer_nxt_s      = timer_r;
    nack_nxt_s       = nack_r;
`ifdef I2C_ARB_RETRY_EN
    retry_cnt_nxt_s  = retry_cnt_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_nxt_s      = pick_s;
          last_grant_nxt_s = pick_s;
          ready0_nxt_s     = ~pick_s;
          ready1_nxt_s     = pick_s;
          data_nxt_s       = pick_s ? req1_data : req0_data;
          go_nxt_s         = 1'b1;
          busy_nxt_s       = 1'b1;
          timer_nxt_s      = '0;
          nack_nxt_s       = 1'b0;
          res_nxt_s        = ST_OK;
`ifdef I2C_ARB_RETRY_EN
          retry_cnt_nxt_s  = '0;
`endif
          state_nxt_s      = S_GO_WAIT;
        end else begin
          go_nxt_s = 1'b0;
        end
      end
      S_GO_WAIT: begin
        if (end_s) begin
          go_nxt_s    = 1'b0;
          nack_nxt_s  = nack_s;
          state_nxt_s = S_RELEASE;
        end else if (timer_r == TMR_LAST) begin
          // Master hung: abort without waiting for end.
          go_nxt_s    = 1'b0;
          res_nxt_s   = ST_TIMEOUT;
          state_nxt_s = S_RESP;
        end else begin
          timer_nxt_s = timer_r + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!end_s) begin
`ifdef I2C_ARB_RETRY_EN
          if (nack_r && (retry_cnt_r < RC_MAX)) begin
            state_nxt_s = S_RETRY;
          end else begin
            res_nxt_s   = nack_r ? ST_NACK : ST_OK;
            state_nxt_s = S_RESP;
          end
`else
          res_nxt_s   = nack_r ? ST_NACK : ST_OK;
          state_nxt_s = S_RESP;
`endif
        end else begin
          state_nxt_s = S_RELEASE;
        end
      end
`ifdef I2C_ARB_RETRY_EN
      S_RETRY: begin
        retry_cnt_nxt_s = retry_cnt_r + 1'b1;
        go_nxt_s        = 1'b1;
        timer_nxt_s     = '0;
        nack_nxt_s      = 1'b0;
        state_nxt_s     = S_GO_WAIT;
      end
`endif
      S_RESP: begin
        done0_nxt_s  = ~grant_r;
        done1_nxt_s  = grant_r;
        status_nxt_s = res_r;
        busy_nxt_s   = 1'b0;
        state_nxt_s  = S_IDLE;
      end
      default: begin
        go_nxt_s    = 1'b0;
        busy_nxt_s  = 1'b0;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  assign req0_ready = ready0_r;
  assign req1_ready = ready1_r;
  assign req0_done  = done0_r;
  assign req1_done  = done1_r;
  assign status     = status_r;
  assign busy       = busy_r;
  assign i2c_data   = data_r;
  assign i2c_go     = go_r;

endmodule
